fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- LDW_OP, 6'd8, double-word load opcode.
- SDW_OP, 6'd9, double-word store opcode.
- CLL_OP, 6'd15, call opcode.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all state updates on the rising edge.
- clear, in, 1, asynchronous active-low reset.
- f_opcode, in, 6, opcode of the word currently read from instruction memory (IF).
- f_rd, in, 4, rd field of the word currently read from instruction memory.
- id_opcode, in, 6, opcode of the instruction in ID.
- br_taken, in, 1, branch in ID resolved taken.
- jr_valid, in, 1, JR in ID.
- jmp_valid, in, 1, J or CLL in ID.
- hazard, in, 1, load-use hazard detected in ID.
- pc_src, out, 2, PC mux select: 0 sequential, 1 branch, 2 jr, 3 jump.
- add_pc, out, 1, 1 = PC+1, 0 = hold PC.
- stall, out, 1, freeze PC and IF/ID buffers.
- kill, out, 1, replace fetched word with 32'h0.
- add_rd, out, 1, second double-word micro-op marker.
- add_imm, out, 1, second double-word micro-op marker.
- turn_off, out, 1, IF buffer write disable.
- call, out, 1, CLL in ID being redirected (R14 link write).

Function
REQ-003 States: RUN, DW2, HALT, held in a registered state; all outputs are combinational from state and inputs.
REQ-004 Priority per cycle: HALT > hazard > redirect > double-word sequencing > sequential fetch.
REQ-005 hazard=1 (not HALT): stall=1, pc_src=0, kill=0, add_pc=1, and the state holds; redirect inputs are ignored that cycle.
REQ-006 Redirect sources and selects:
- br_taken: pc_src=1.
- jr_valid: pc_src=2.
- jmp_valid: pc_src=3.
- If more than one is asserted, select jmp_valid, then jr_valid, then br_taken.
REQ-007 Redirect, in RUN or DW2 with hazard=0: kill=1, stall=0, add_rd=0, add_imm=0, and the next state is RUN (an in-flight DW2 is aborted).
REQ-008 call=1 only in a jmp_valid redirect cycle with id_opcode==CLL_OP; call=0 otherwise.
REQ-009 RUN, no hazard, no redirect, f_opcode in {LDW_OP, SDW_OP}: add_pc=0 (PC held), next state DW2, and the first micro-op passes with add_rd=add_imm=0.
REQ-010 DW2, no hazard, no redirect: add_pc=1, add_rd=1, add_imm=1, next state RUN; exactly one second micro-op per double-word instruction.
REQ-011 RUN, non-double-word opcode: add_pc=1, pc_src=0, all other outputs 0.
REQ-012 Back-to-back double-word instructions: RUN, DW2, RUN, DW2, with no lost cycle.
REQ-013 turn_off=1 only in HALT, where stall=1, kill=1, add_pc=0; HALT exits only through reset.

Reset
REQ-014 While clear=0, state=RUN asynchronously and outputs are forced: pc_src=0, add_pc=1, stall=0, kill=1, add_rd=0, add_imm=0, turn_off=0, call=0.
REQ-015 Deassertion of clear is taken at the next clk rising edge, and the first post-reset cycle behaves as RUN.
REQ-016 Reset asserted in DW2 or HALT abandons the sequence; no second micro-op is issued after reset.

Configuration
REQ-017 Macro DW_ODD_RD_TRAP_EN defined: in RUN, a double-word opcode with f_rd[0]=1 (no hazard or redirect) goes to HALT next cycle instead of DW2, and the first micro-op is killed.
REQ-018 Macro DW_ODD_RD_TRAP_EN undefined: odd f_rd is sequenced exactly as even f_rd, HALT is unreachable, and turn_off is tied to 0.

Verification
REQ-019 Reset, then clear=1, f_opcode=6'd5 for 4 cycles -> each cycle add_pc=1, pc_src=0, stall=kill=0.
REQ-020 f_opcode=LDW_OP, f_rd=4'd2 -> cycle N: add_pc=0, add_rd=0; cycle N+1: add_pc=1, add_rd=add_imm=1; cycle N+2: RUN.
REQ-021 In DW2, br_taken=1 -> pc_src=1, kill=1, add_rd=0, next state RUN; no later add_rd pulse.
REQ-022 hazard=1 together with jmp_valid=1 and id_opcode=CLL_OP -> stall=1, pc_src=0, call=0; next cycle hazard=0 -> pc_src=3, kill=1, call=1.
REQ-023 jr_valid=1 and br_taken=1 together -> pc_src=2.
REQ-024 With DW_ODD_RD_TRAP_EN defined, f_opcode=SDW_OP, f_rd=4'd3 -> next cycle turn_off=stall=kill=1, held 5 cycles; clear=0 -> turn_off=0 asynchronously.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencing controller.
// Picks the PC source, stalls on load-use hazards, kills wrong-path fetches,
// splits double-word loads/stores into two micro-ops and owns the HALT trap.
// Optional feature macro: DW_ODD_RD_TRAP_EN -- a double-word opcode with an odd
// rd traps to HALT instead of being sequenced.
// The state is registered; every output is combinational from state and inputs.
module fetch_ctrl #(
  parameter logic [5:0] LDW_OP = 6'd8,
  parameter logic [5:0] SDW_OP = 6'd9,
  parameter logic [5:0] CLL_OP = 6'd15
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [5:0] f_opcode,
  input  logic [3:0] f_rd,
  input  logic [5:0] id_opcode,
  input  logic       br_taken,
  input  logic       jr_valid,
  input  logic       jmp_valid,
  input  logic       hazard,
  output logic [1:0] pc_src,
  output logic       add_pc,
  output logic       stall,
  output logic       kill,
  output logic       add_rd,
  output logic       add_imm,
  output logic       turn_off,
  output logic       call
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_DW2  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JR  = 2'd2;
  localparam logic [1:0] PC_JMP = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_is_dw;
  logic       w_redirect;
  logic [1:0] w_redir_sel;
  logic       w_unused;

  // True when the fetched opcode needs two micro-ops.
  function automatic logic is_dw_op(input logic [5:0] op);
    return (op == LDW_OP) || (op == SDW_OP);
  endfunction

  // Redirect select: jump beats jr beats branch when several fire together.
  function automatic logic [1:0] redir_select(input logic br, input logic jr, input logic jmp);
    logic [1:0] sel;
    if (jmp) begin
      sel = PC_JMP;
    end else if (jr) begin
      sel = PC_JR;
    end else if (br) begin
      sel = PC_BR;
    end else begin
      sel = PC_SEQ;
    end
    return sel;
  endfunction

  assign w_is_dw     = is_dw_op(f_opcode);
  assign w_redirect  = br_taken | jr_valid | jmp_valid;
  assign w_redir_sel = redir_select(br_taken, jr_valid, jmp_valid);

`ifdef DW_ODD_RD_TRAP_EN
  assign w_unused = ^f_rd[3:1];
`else
  assign w_unused = ^f_rd;
`endif

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: HALT sticks, hazard freezes, redirect aborts, then DW sequencing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      ST_RUN, ST_DW2: begin
        if (hazard) begin
          w_state_nxt = r_state;
        end else if (w_redirect) begin
          w_state_nxt = ST_RUN;
        end else if (r_state == ST_DW2) begin
          w_state_nxt = ST_RUN;
        end else if (w_is_dw) begin
`ifdef DW_ODD_RD_TRAP_EN
          if (f_rd[0]) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt = ST_DW2;
          end
`else
          w_state_nxt = ST_DW2;
`endif
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Outputs: reset override first, then the same priority order as the next state.
  always_comb begin
    pc_src   = PC_SEQ;
    add_pc   = 1'b1;
    stall    = 1'b0;
    kill     = 1'b0;
    add_rd   = 1'b0;
    add_imm  = 1'b0;
    turn_off = 1'b0;
    call     = 1'b0;
    if (!clear) begin
      kill = 1'b1;
    end else begin
      case (r_state)
        ST_HALT: begin
          stall  = 1'b1;
          kill   = 1'b1;
          add_pc = 1'b0;
`ifdef DW_ODD_RD_TRAP_EN
          turn_off = 1'b1;
`else
          turn_off = 1'b0;
`endif
        end
        ST_RUN, ST_DW2: begin
          if (hazard) begin
            stall = 1'b1;
          end else if (w_redirect) begin
            pc_src = w_redir_sel;
            kill   = 1'b1;
            call   = jmp_valid && (id_opcode == CLL_OP);
          end else if (r_state == ST_DW2) begin
            add_rd  = 1'b1;
            add_imm = 1'b1;
          end else if (w_is_dw) begin
            // Hold the PC so the same word is presented for the second micro-op.
            add_pc = 1'b0;
`ifdef DW_ODD_RD_TRAP_EN
            if (f_rd[0]) begin
              kill = 1'b1;
            end else begin
              kill = 1'b0;
            end
`endif
          end else begin
            add_pc = 1'b1;
          end
        end
        default: begin
          kill = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each directed step pushes its expected
// output vector; a monitor on the falling edge pops and compares.
module tb_fetch_ctrl;

  logic       clk;
  logic       clear;
  logic [5:0] f_opcode;
  logic [3:0] f_rd;
  logic [5:0] id_opcode;
  logic       br_taken;
  logic       jr_valid;
  logic       jmp_valid;
  logic       hazard;
  logic [1:0] pc_src;
  logic       add_pc;
  logic       stall;
  logic       kill;
  logic       add_rd;
  logic       add_imm;
  logic       turn_off;
  logic       call;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } item_t;

  item_t q[$];
  item_t cur;
  int    checks;
  int    errors;

  localparam logic [5:0] OP_LDW = 6'd8;
  localparam logic [5:0] OP_SDW = 6'd9;
  localparam logic [5:0] OP_CLL = 6'd15;
  localparam logic [5:0] OP_ALU = 6'd5;

  fetch_ctrl dut (
    .clk      (clk),
    .clear    (clear),
    .f_opcode (f_opcode),
    .f_rd     (f_rd),
    .id_opcode(id_opcode),
    .br_taken (br_taken),
    .jr_valid (jr_valid),
    .jmp_valid(jmp_valid),
    .hazard   (hazard),
    .pc_src   (pc_src),
    .add_pc   (add_pc),
    .stall    (stall),
    .kill     (kill),
    .add_rd   (add_rd),
    .add_imm  (add_imm),
    .turn_off (turn_off),
    .call     (call)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {pc_src, add_pc, stall, kill, add_rd, add_imm, turn_off, call}
  function automatic logic [8:0] ev(input logic [1:0] ps, input logic ap, input logic st,
                                    input logic kl, input logic ar, input logic ai,
                                    input logic to, input logic cl);
    return {ps, ap, st, kl, ar, ai, to, cl};
  endfunction

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      checks = checks + 1;
      if ({pc_src, add_pc, stall, kill, add_rd, add_imm, turn_off, call} !== cur.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %b want %b (pc_src,add_pc,stall,kill,add_rd,add_imm,turn_off,call)",
                 cur.name,
                 {pc_src, add_pc, stall, kill, add_rd, add_imm, turn_off, call}, cur.exp);
      end
    end
  end

  // One cycle of stimulus, driven just after the rising edge, with its expectation.
  task automatic step(input logic clr, input logic [5:0] opc, input logic [3:0] rd,
                      input logic [5:0] idop, input logic br, input logic jr,
                      input logic jmp, input logic hz, input logic [8:0] exp,
                      input string name);
    item_t it;
    @(posedge clk);
    #1;
    clear     = clr;
    f_opcode  = opc;
    f_rd      = rd;
    id_opcode = idop;
    br_taken  = br;
    jr_valid  = jr;
    jmp_valid = jmp;
    hazard    = hz;
    it.exp    = exp;
    it.name   = name;
    q.push_back(it);
  endtask

  logic [8:0] v_seq, v_rst, v_dw1, v_dw2, v_haz;

  initial begin
    checks    = 0;
    errors    = 0;
    clear     = 1'b0;
    f_opcode  = 6'd0;
    f_rd      = 4'd0;
    id_opcode = 6'd0;
    br_taken  = 1'b0;
    jr_valid  = 1'b0;
    jmp_valid = 1'b0;
    hazard    = 1'b0;
    v_seq = ev(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_rst = ev(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    v_dw1 = ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_dw2 = ev(2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    v_haz = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    step(1'b0, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_rst, "reset0");
    step(1'b0, OP_LDW, 4'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_rst, "reset_ldw");

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "seq");
    end

    // Single double-word load
    step(1'b1, OP_LDW, 4'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw1, "ldw_first");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw2, "ldw_second");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "ldw_back_run");

    // Back-to-back double-words
    step(1'b1, OP_LDW, 4'd4, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw1, "b2b_a1");
    step(1'b1, OP_LDW, 4'd4, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw2, "b2b_a2");
    step(1'b1, OP_SDW, 4'd6, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw1, "b2b_b1");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw2, "b2b_b2");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "b2b_run");

    // Branch aborts DW2
    step(1'b1, OP_LDW, 4'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw1, "abort_first");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0,
         ev(2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "abort_br");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "abort_no_rd1");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "abort_no_rd2");

    // Hazard beats a CLL redirect, then the redirect goes through
    step(1'b1, OP_ALU, 4'd0, OP_CLL, 1'b0, 1'b0, 1'b1, 1'b1, v_haz, "haz_cll");
    step(1'b1, OP_ALU, 4'd0, OP_CLL, 1'b0, 1'b0, 1'b1, 1'b0,
         ev(2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "cll_redirect");
    step(1'b1, OP_ALU, 4'd0, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0,
         ev(2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "jmp_no_call");

    // Redirect priority
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0,
         ev(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "jr_over_br");
    step(1'b1, OP_ALU, 4'd0, OP_CLL, 1'b1, 1'b1, 1'b1, 1'b0,
         ev(2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "jmp_over_all");
    step(1'b1, OP_ALU, 4'd0, OP_CLL, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "cll_opcode_no_jmp");

    // Hazard in DW2 holds the state
    step(1'b1, OP_SDW, 4'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw1, "hz_dw_first");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, v_haz, "hz_in_dw2");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw2, "hz_dw_second");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "hz_dw_run");

    // Hazard and redirect in RUN with a double-word opcode present
    step(1'b1, OP_LDW, 4'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, v_haz, "hz_run_ldw");
    step(1'b1, OP_LDW, 4'd2, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0,
         ev(2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "br_run_ldw");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "br_run_ldw_next");

    // Reset in DW2 abandons the second micro-op
    step(1'b1, OP_LDW, 4'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw1, "rst_dw_first");
    step(1'b0, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_rst, "rst_in_dw2");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "rst_dw_after");

`ifdef DW_ODD_RD_TRAP_EN
    // Odd rd traps to HALT
    step(1'b1, OP_SDW, 4'd3, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0,
         ev(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "trap_first_killed");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OP_LDW, 4'd2, OP_CLL, (i == 1), (i == 2), (i == 3), (i == 4),
           ev(2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), "halt_hold");
    end
    step(1'b0, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_rst, "halt_async_clear");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "halt_exit_run");
`else
    // Odd rd sequences like even rd
    step(1'b1, OP_SDW, 4'd3, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw1, "odd_rd_first");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_dw2, "odd_rd_second");
    step(1'b1, OP_ALU, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_seq, "odd_rd_run");
`endif

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
